// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared types and constants for the instruction sequencer.
// Build option INSTR_SEQ_JUMP_EN enables J-format jump sequencing.
package instr_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam int OPC_HI  = 31;
    localparam int OPC_LO  = 26;
    localparam int JTGT_LO = 0;

    function automatic logic is_jump(input logic [31:0] w);
        return w[OPC_HI:OPC_LO] == OP_J;
    endfunction

endpackage

// File: rtl/instr_seq_mem.sv
// instr_seq_mem: DEPTH x 32 program store.
// Synchronous write, combinational read, contents survive reset.
module instr_seq_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // program write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: program store and issue sequencer for the processor.
// Build option INSTR_SEQ_JUMP_EN follows J-format jumps in WAIT.
module instr_sequencer
    import instr_seq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int MAX_ISSUE = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          done,
    output logic [31:0]   instruction,
    output logic          issue_valid,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          finished,
    output logic [7:0]    issued_count
);

    state_t        state;
    state_t        state_n;
    logic [AW:0]   len_q;
    logic [AW-1:0] pc_q;
    logic [7:0]    cnt_q;
    logic [31:0]   instr_q;
    logic          done_q;
    logic          done_rise;
    logic          idle_like;
    logic          mem_we;
    logic          start_ok;
    logic [AW:0]   next_pc;
    logic          halt_now;
    logic [31:0]   rd_data;

    assign done_rise = done & ~done_q;
    assign idle_like = (state == S_IDLE) || (state == S_HALT);
    assign mem_we    = wr_en & idle_like;
    assign start_ok  = start & idle_like;

    instr_seq_mem #(
        .DEPTH(DEPTH),
        .AW   (AW)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .waddr(wr_addr),
        .wdata(wr_data),
        .raddr(pc_q),
        .rdata(rd_data)
    );

    // next pc at AW+1 bits so len_q == DEPTH compares without wrap
    always_comb begin
        next_pc = {1'b0, pc_q} + {{AW{1'b0}}, 1'b1};
`ifdef INSTR_SEQ_JUMP_EN
        if (is_jump(instr_q)) next_pc = {1'b0, instr_q[JTGT_LO +: AW]};
`endif
        halt_now = (next_pc >= len_q) || (cnt_q == 8'(MAX_ISSUE));
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    if (prog_len == '0) state_n = S_HALT;
                    else                state_n = S_FETCH;
                end
            end
            S_FETCH: state_n = S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (done_rise) begin
                    if (halt_now) state_n = S_HALT;
                    else          state_n = S_FETCH;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // run datapath: length, pc, issue count, fetched word, done history
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done;
            if (start_ok) begin
                len_q <= prog_len;
                pc_q  <= '0;
                cnt_q <= '0;
            end
            if (state == S_FETCH) instr_q <= rd_data;
            if (state == S_ISSUE) cnt_q <= cnt_q + 8'd1;
            if (state == S_WAIT && done_rise && !halt_now)
                pc_q <= next_pc[AW-1:0];
        end
    end

    assign instruction  = instr_q;
    assign issue_valid  = (state == S_ISSUE);
    assign pc           = pc_q;
    assign busy         = (state == S_FETCH) || (state == S_ISSUE) ||
                          (state == S_WAIT);
    assign finished     = (state == S_HALT);
    assign issued_count = cnt_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program store and issue sequencer sitting directly upstream of `Processor`. It holds up to `DEPTH` 32-bit MIPS-style encodings and presents one at a time on `instruction`. It advances only after the processor signals completion with a rising edge on `done`, which replaces bench-driven instruction stepping. It reports progress, program end and an issue count to the surrounding top.

## Interface
Parameters:
- `DEPTH`, 8: program store entries (power of two).
- `AW`, 3: address width, equal to log2(`DEPTH`).
- `MAX_ISSUE`, 255: issue budget per run; 8-bit counter limit.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  program write strobe.
- `wr_addr`  in  AW  program write address.
- `wr_data`  in  32  program write data.
- `prog_len`  in  AW+1  number of valid entries, 1..DEPTH; sampled on `start`.
- `start`  in  1  begin a run from address 0.
- `done`  in  1  processor completion level; only its rising edge is used.
- `instruction`  out  32  encoding currently issued.
- `issue_valid`  out  1  one-cycle pulse when `instruction` changes to a new issue.
- `pc`  out  AW  address of the issued instruction.
- `busy`  out  1  run in progress.
- `finished`  out  1  run ended, held high.
- `issued_count`  out  8  instructions issued in this run.

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, HALT.
- **IDLE:**
  - Writes are accepted.
  - `start` latches `prog_len` into `len_q`, clears `pc` and `issued_count`, and goes to FETCH.
  - `start` with `prog_len`==0 goes directly to HALT.
- **FETCH:** registers `mem[pc]` into `instr_q`, then goes to ISSUE.
- **ISSUE:**
  - Drives `instruction`=`instr_q`.
  - Pulses `issue_valid`.
  - Increments `issued_count`.
  - Goes to WAIT.
- **WAIT:**
  - On `done_rise` = `done` & ~`done_q`, computes the next pc, which defaults to `pc`+1.
  - Goes to HALT if the next pc ≥ `len_q` or `issued_count`==`MAX_ISSUE`; otherwise goes to FETCH.
- **HALT:**
  - `finished`=1 and `busy`=0.
  - `start` re-enters as from IDLE.
  - Writes are accepted.
- Writes in FETCH, ISSUE or WAIT are ignored, so the program cannot be modified mid-run.
- A `start` that is asserted while busy is ignored.
- `done` already high on entry to WAIT does not count; a fresh rising edge is required.
- `done_q` is updated every cycle in every state, so an edge that occurs during FETCH or ISSUE is lost.
- The next-pc addition is performed at width AW+1 so that the comparison against `len_q`=DEPTH is exact and does not wrap.
- `instruction` holds its last value in HALT and IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `instruction`=0 and `issue_valid`=0.
  - `pc`=0 and `issued_count`=0.
  - `busy`=0 and `finished`=0.
  - `done_q`=0.
  - Program memory is not cleared by reset.
- Latency from `start` to `issue_valid` is 2 cycles: FETCH, then ISSUE.
- Latency from `done_rise` in WAIT to the next `issue_valid` is 2 cycles.
- `busy` is high in FETCH, ISSUE and WAIT.
- A write to an address in the same cycle as FETCH reading that address is impossible, because writes are blocked.
- `reset` asserted mid-run returns to IDLE on the next edge; all outputs take their reset values.

## Configuration
- The macro is `INSTR_SEQ_JUMP_EN`.
- **With the macro defined:**
  - In WAIT, if `instr_q[31:26]`==6'b000010 (J-format `j`), the next pc is `instr_q[AW-1:0]` instead of `pc`+1.
  - A jump target ≥ `len_q` halts the run.
  - `MAX_ISSUE` bounds infinite loops.
- **Without the macro:** jumps are sequenced as ordinary instructions and the next pc is always `pc`+1.

## Structure
- Shared package `instr_seq_pkg` contains:
  - the state enum.
  - opcode constants `OP_RTYPE`=6'b000000, `OP_J`=6'b000010 and `OP_ADDI`=6'b001000.
  - the field-slice localparams for the opcode and the jump target.
- One sub-module, `instr_seq_mem`:
  - `DEPTH`×32 register array.
  - synchronous write.
  - combinational read.
  - no reset.
- The FSM, `done` edge detection and counters live in the `instr_sequencer` top.

## Test plan
- Load 8 encodings, `prog_len`=8, `start`, then `done` pulsed 4 cycles after each issue -> 8 `issue_valid` pulses with `pc` values 0..7; `finished`=1; `issued_count`=8.
- Hold `done` high through WAIT without a new edge -> no advance; `pc` stays fixed until `done` falls and rises again.
- `INSTR_SEQ_JUMP_EN` defined, word 7 = 32'h08123456 (target low bits 6), `prog_len`=8 -> after pc 7 the next issue has pc=6, alternating 6/7 until `issued_count`=255, then HALT.
- `wr_en` to address 2 during WAIT -> the write is ignored; the next run still issues the original word at pc 2.
- `reset` asserted in WAIT after 3 issues -> next cycle: IDLE with all outputs 0; program memory intact; re-`start` issues word 0.
- `prog_len`=0 with `start` -> HALT in 1 cycle; `issue_valid` never pulses; `issued_count`=0.
